// File: rtl/booth_dot_acc.sv
// Dot-product accumulator for the booth multiplier: sums LEN signed products with
// per-step saturation and hands the group result out over a valid/ready port.
module booth_dot_acc #(
   parameter int WIDTH = 6,
   parameter int LEN   = 4,
   parameter int ACC_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [2*WIDTH-1:0]   prod,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_W-1:0]     acc_out,
   output logic                        ovf
);

   localparam int CNT_W = (LEN > 2) ? $clog2(LEN) : 1;
   localparam logic signed [ACC_W:0] MAX_X = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MIN_X = {2'b11, {(ACC_W-1){1'b0}}};

   typedef enum logic {ACC, DONE} state_t;

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt;
   logic signed [ACC_W-1:0]  acc;
   logic                     ovf_int;
   logic                     accept;
   logic                     last;
   logic signed [ACC_W:0]    sum;
   logic signed [ACC_W-1:0]  sum_sat;
   logic                     sum_hit;

   function automatic logic signed [ACC_W-1:0] sat_val(input logic signed [ACC_W:0] s);
      if (s > MAX_X)
         return MAX_X[ACC_W-1:0];
      else if (s < MIN_X)
         return MIN_X[ACC_W-1:0];
      else
         return s[ACC_W-1:0];
   endfunction

   function automatic logic sat_hit(input logic signed [ACC_W:0] s);
      return (s > MAX_X) || (s < MIN_X);
   endfunction

   // One guard bit above the accumulator keeps the raw sum exact before clamping.
   always_comb begin
      sum     = $signed({acc[ACC_W-1], acc})
              + $signed({{(ACC_W+1-2*WIDTH){prod[2*WIDTH-1]}}, prod});
      sum_sat = sat_val(sum);
      sum_hit = sat_hit(sum);
      accept  = in_valid && in_ready;
      last    = (cnt == CNT_W'(LEN-1));
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= ACC;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (accept && last) state_nxt = DONE;
         DONE:    if (out_ready)      state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   always_comb begin
      in_ready  = !rst && (state == ACC);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         ovf_int <= 1'b0;
         acc_out <= '0;
         ovf     <= 1'b0;
      end else if (accept) begin
         if (last) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
            acc_out <= sum_sat;
            ovf     <= ovf_int | sum_hit;
         end else begin
            acc     <= sum_sat;
            cnt     <= cnt + CNT_W'(1);
            ovf_int <= ovf_int | sum_hit;
         end
      end
   end

endmodule
